// File: rtl/dff_cap_pkg.sv
// Shared types and default parameter values for the DFF serial capture block.
package dff_cap_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOAD = 1'b1
  } cap_state_e;

  localparam int         DEF_WORD_W      = 8;
  localparam logic [7:0] DEF_SYNC_WORD   = 8'hA5;
  localparam int         DEF_FRAME_WORDS = 4;
  localparam int         DEF_CNT_W       = 8;

endpackage

// File: rtl/cap_fifo2.sv
// Two-entry in-order FIFO with a valid/ready output side.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module cap_fifo2
  import dff_cap_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  output logic              full,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid,
  input  logic              word_ready
);

  logic [WORD_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic              pop;
  logic              accept;

  assign word_valid = (count != 2'd0);
  assign full       = (count == 2'd2);
  assign pop        = word_valid & word_ready;
  assign accept     = push & (~full | pop);
  assign word_o     = mem[rd_ptr];

  // Storage, pointers and occupancy; a full-buffer push reuses the slot freed by the pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (accept) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      count <= count + {1'b0, accept} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/dff_serial_capture.sv
// Serial capture of the DFF output stream: hunts for a sync word, then packs
// the following bits MSB-first into words delivered through a 2-entry buffer.
module dff_serial_capture
  import dff_cap_pkg::*;
#(
  parameter int                WORD_W      = DEF_WORD_W,
  parameter logic [WORD_W-1:0] SYNC_WORD   = WORD_W'(DEF_SYNC_WORD),
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int                CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sdi,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              locked,
  output logic              frame_done,
  output logic [CNT_W-1:0]  ovf_cnt
);

  localparam int FILL_W = $clog2(WORD_W + 1);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int WC_W   = $clog2(FRAME_WORDS + 1);

  cap_state_e         state;
  // The shift register MSB is shifted out on the very next bit, so only the
  // WORD_W-1 history bits are kept; the full window is formed with sdi.
  logic [WORD_W-2:0]  hist;
  logic [WORD_W-1:0]  shn;
  logic [FILL_W-1:0]  fill;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WC_W-1:0]    word_cnt;
  logic               bit_last;
  logic               word_last;
  logic               push;
  logic               full;
  logic               drop;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [FILL_W-1:0] sat_inc_fill(input logic [FILL_W-1:0] v);
    return (v == FILL_W'(WORD_W)) ? v : v + FILL_W'(1);
  endfunction

  assign shn       = {hist, sdi};
  assign bit_last  = (bit_cnt == BIT_W'(WORD_W - 1));
  assign word_last = (word_cnt == WC_W'(FRAME_WORDS - 1));
  assign push      = en & (state == LOAD) & bit_last;
  assign drop      = push & full & ~(word_valid & word_ready);

  cap_fifo2 #(
    .WORD_W(WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shn),
    .full      (full),
    .word_o    (word_o),
    .word_valid(word_valid),
    .word_ready(word_ready)
  );

  // Sync hunt / word load FSM with shift history, counters and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      hist       <= '0;
      fill       <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (drop) begin
        ovf_cnt <= sat_inc_cnt(ovf_cnt);
      end
      if (en) begin
        hist <= shn[WORD_W-2:0];
        unique case (state)
          HUNT: begin
            // fill guarantees every window bit arrived after this hunt began
            if ((fill >= FILL_W'(WORD_W - 1)) && (shn == SYNC_WORD)) begin
              state    <= LOAD;
              locked   <= 1'b1;
              bit_cnt  <= '0;
              word_cnt <= '0;
            end else begin
              fill <= sat_inc_fill(fill);
            end
          end
          LOAD: begin
            if (bit_last) begin
              bit_cnt  <= '0;
              word_cnt <= word_cnt + WC_W'(1);
              if (word_last) begin
                state      <= HUNT;
                locked     <= 1'b0;
                frame_done <= 1'b1;
                fill       <= '0;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dff_serial_capture.sv
// Directed bench for dff_serial_capture with a word scoreboard.
module tb_dff_serial_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sdi = 1'b0;
  logic       word_ready = 1'b0;
  logic [7:0] word_o;
  logic       word_valid;
  logic       locked;
  logic       frame_done;
  logic [7:0] ovf_cnt;

  logic [7:0] sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int fd_mark;

  always #5 clk = ~clk;

  dff_serial_capture #(
    .WORD_W(8), .SYNC_WORD(8'hA5), .FRAME_WORDS(2), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sdi       (sdi),
    .word_o    (word_o),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .locked    (locked),
    .frame_done(frame_done),
    .ovf_cnt   (ovf_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every accepted word must match the scoreboard head
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (word_valid === 1'b1 && word_ready === 1'b1) begin
      check("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) check("word_out", word_o, sb.pop_front());
    end
  end

  task automatic send_bit(input logic b);
    en = 1'b1;
    sdi = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Sends bits 7..1 only; caller sends bit 0 to observe the final-bit edge
  task automatic send_byte_hold(input logic [7:0] b);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
  endtask

  // en alternates 0/1; returns right after the final enabled bit
  task automatic send_byte_slow(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      idle(1);
      send_bit(b[i]);
    end
  endtask

  task automatic drain(input string tag);
    word_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
    idle(2);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_valid_low"}, word_valid, 0);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("por_valid", word_valid, 0);
    check("por_locked", locked, 0);
    check("por_ovf", ovf_cnt, 0);
    rst_n = 1'b1;
    word_ready = 1'b1;
    idle(2);

    // Basic frame: A5, 3C, C3
    fd_mark = fd_cnt;
    send_byte_hold(8'hA5);
    check("t2_prelock", locked, 0);
    send_bit(1'b1);
    check("t2_locked", locked, 1);
    sb.push_back(8'h3C);
    send_byte_hold(8'h3C);
    check("t2_valid_bit15", word_valid, 0);
    send_bit(1'b0);
    check("t2_valid_bit16", word_valid, 1);
    check("t2_word_3c", word_o, 8'h3C);
    sb.push_back(8'hC3);
    send_byte(8'hC3);
    check("t2_fd", frame_done, 1);
    check("t2_unlock", locked, 0);
    check("t2_word_c3", word_o, 8'hC3);
    idle(1);
    check("t2_fd_pulse", frame_done, 0);
    drain("t2");
    check("t2_fd_count", fd_cnt - fd_mark, 1);

    // Misaligned near-sync, then aligned sync
    fd_mark = fd_cnt;
    send_byte(8'hA4);
    send_byte_hold(8'hA5);
    check("t3_nolock", locked, 0);
    send_bit(1'b1);
    check("t3_lock", locked, 1);
    sb.push_back(8'h5A);
    send_byte(8'h5A);
    sb.push_back(8'h96);
    send_byte(8'h96);
    check("t3_fd", frame_done, 1);
    // Tail "10" of 96 plus these 6 bits form A5, which must not lock
    for (int i = 0; i < 6; i++) begin
      logic [5:0] pat;
      pat = 6'b100101;
      send_bit(pat[5 - i]);
    end
    check("t3_straddle", locked, 0);
    send_byte(8'h00);
    check("t3_no_lock_zero", locked, 0);
    drain("t3");
    check("t3_fd_count", fd_cnt - fd_mark, 1);

    // Same frame with en toggling every cycle
    fd_mark = fd_cnt;
    send_byte_slow(8'hA5);
    check("t5_locked", locked, 1);
    sb.push_back(8'h3C);
    send_byte_slow(8'h3C);
    check("t5_valid", word_valid, 1);
    check("t5_word_3c", word_o, 8'h3C);
    idle(1);
    check("t5_pop_en0", word_valid, 0);
    sb.push_back(8'hC3);
    send_byte_slow(8'hC3);
    check("t5_fd", frame_done, 1);
    check("t5_unlock", locked, 0);
    check("t5_word_c3", word_o, 8'hC3);
    idle(1);
    check("t5_fd_pulse", frame_done, 0);
    drain("t5");
    check("t5_fd_count", fd_cnt - fd_mark, 1);

    // Backpressure: buffer fills, extra words dropped, counter saturates
    word_ready = 1'b0;
    send_byte(8'hA5);
    sb.push_back(8'h3C);
    send_byte(8'h3C);
    sb.push_back(8'hC3);
    send_byte(8'hC3);
    send_byte(8'hA5);
    send_byte(8'h11);
    check("t4_ovf1", ovf_cnt, 1);
    send_byte(8'h22);
    check("t4_ovf2", ovf_cnt, 2);
    check("t4_head", word_o, 8'h3C);
    idle(3);
    check("t4_hold_valid", word_valid, 1);
    check("t4_hold_word", word_o, 8'h3C);
    for (int f = 0; f < 130; f++) begin
      send_byte(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
    end
    check("t4_ovf_sat", ovf_cnt, 8'hFF);
    check("t4_head_after", word_o, 8'h3C);
    drain("t4");

    // Asynchronous reset mid-run with outputs active
    word_ready = 1'b0;
    send_byte(8'hA5);
    sb.push_back(8'h3C);
    send_byte(8'h3C);
    sb.push_back(8'hC3);
    send_byte(8'hC3);
    check("t1_pre_fd", frame_done, 1);
    check("t1_pre_valid", word_valid, 1);
    check("t1_pre_ovf", ovf_cnt, 8'hFF);
    rst_n = 1'b0;
    #1;
    check("t1_valid", word_valid, 0);
    check("t1_locked", locked, 0);
    check("t1_fd", frame_done, 0);
    check("t1_ovf", ovf_cnt, 0);
    check("t1_word", word_o, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    word_ready = 1'b1;
    idle(1);

    // Reset while loading, then resync
    fd_mark = fd_cnt;
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] pat;
      pat = 4'b0011;
      send_bit(pat[3 - i]);
    end
    check("t6_locked", locked, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_unlock", locked, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'h3C);
    check("t6_nosync_lock", locked, 0);
    check("t6_nosync_valid", word_valid, 0);
    send_byte(8'hA5);
    check("t6_relock", locked, 1);
    sb.push_back(8'h3C);
    send_byte(8'h3C);
    sb.push_back(8'hC3);
    send_byte(8'hC3);
    check("t6_fd", frame_done, 1);
    check("t6_word_c3", word_o, 8'hC3);
    drain("t6");
    check("t6_fd_count", fd_cnt - fd_mark, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
